// File: rtl/seven_seg_scan.sv
// seven_seg_scan: four-digit multiplexed seven-segment driver with per-slot blanking.
// Optional SEVSEG_HEXDEC_EN adds hex decode for digit words with bit15 set.
module seven_seg_scan #(
    parameter int DIV   = 2000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        A, B, C, D, E, F, G, H, I,
    output logic        DP,
    output logic        CC1, CC2, CC3, CC4
);
    localparam logic [0:0] DARK = 1'b0;
    localparam logic [0:0] LIT  = 1'b1;
    logic [15:0] digit [4];
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [0:0]  state;
    logic [15:0] cur;
    logic [8:0]  seg, seg_q;
    logic [3:0]  cc_q;
    logic        dp_q, wrap;
    logic        unused;
    assign wrap   = cnt == 16'(DIV - 1);
    assign cur    = digit[idx];
    assign dout   = digit[addr];
    assign unused = ^{cur[14:10], cur[15]};
`ifdef SEVSEG_HEXDEC_EN
    localparam logic [6:0] HEX [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };
    assign seg = cur[15] ? {2'b00, HEX[cur[3:0]]} : cur[8:0];
`else
    assign seg = cur[8:0];
`endif
    // State tracks the counter value so the registered outputs lag it by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) digit[k] <= '0;
            cnt   <= '0;
            idx   <= '0;
            state <= DARK;
            seg_q <= '0;
            dp_q  <= 1'b0;
            cc_q  <= 4'hf;
        end else begin
            if (we) digit[addr] <= din;
            cnt   <= wrap ? '0 : cnt + 16'd1;
            idx   <= wrap ? idx + 2'd1 : idx;
            state <= wrap ? DARK : (cnt == 16'(BLANK - 1)) ? LIT : state;
            seg_q <= (state == LIT) ? seg : '0;
            dp_q  <= (state == LIT) && cur[9];
            cc_q  <= (state == LIT) ? ~(4'b0001 << idx) : 4'hf;
        end
    end
    assign {I, H, G, F, E, D, C, B, A} = seg_q;
    assign DP = dp_q;
    assign {CC4, CC3, CC2, CC1} = cc_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: vector table plus scoreboard for seven_seg_scan at DIV=8, BLANK=2.
module tb_seven_seg_scan;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
`ifdef SEVSEG_HEXDEC_EN
    localparam logic [6:0] HEXP [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };
    localparam logic [6:0] HEX8_EXP = 7'h7f;
`else
    localparam logic [6:0] HEX8_EXP = 7'h08;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic we = 1'b0;
    logic [1:0] addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic A, B, C, D, E, F, G, H, I, DP, CC1, CC2, CC3, CC4;
    always #5 clk = ~clk;
    seven_seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I),
        .DP(DP), .CC1(CC1), .CC2(CC2), .CC3(CC3), .CC4(CC4)
    );
    typedef struct packed {
        logic [3:0] cc;
        logic [8:0] seg;
        logic       dp;
    } obs_t;
    typedef struct {
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] rd;
    } vec_t;
    obs_t sb [$];
    logic [15:0] mreg [4];
    int e = 0;
    int errors = 0;
    int checks = 0;
    // Expected outputs after edge n (edges counted from reset release), from slot timing.
    function automatic obs_t expect_at(int n);
        obs_t o;
        int p, slot;
        logic [15:0] w;
        o = '{cc: 4'hf, seg: 9'd0, dp: 1'b0};
        if (n > 0) begin
            p = n - 1;
            slot = (p / DIV) % 4;
            if (p % DIV >= BLANK) begin
                w = mreg[slot];
                o.cc = ~(4'b0001 << slot);
                o.seg = w[8:0];
`ifdef SEVSEG_HEXDEC_EN
                if (w[15]) o.seg = {2'b00, HEXP[w[3:0]]};
`endif
                o.dp = w[9];
            end
        end
        return o;
    endfunction
    function automatic obs_t actual();
        return '{cc: {CC4, CC3, CC2, CC1}, seg: {I, H, G, F, E, D, C, B, A}, dp: DP};
    endfunction
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input logic w, input logic [1:0] a, input logic [15:0] d);
        obs_t x, o;
        we = w;
        addr = a;
        din = d;
        sb.push_back(expect_at(e + 1));
        if (w) mreg[a] = d;
        @(posedge clk);
        e++;
        @(negedge clk);
        we = 1'b0;
        x = sb.pop_front();
        o = actual();
        check($sformatf("cc@%0d", e), 16'(o.cc), 16'(x.cc));
        check($sformatf("seg@%0d", e), 16'(o.seg), 16'(x.seg));
        check($sformatf("dp@%0d", e), 16'(o.dp), 16'(x.dp));
        check($sformatf("cc_excl@%0d", e), 16'($countones(~o.cc) <= 1), 16'd1);
    endtask
    task automatic do_reset();
        obs_t o;
        reset = 1'b1;
        #1;
        o = actual();
        check("rst_async_cc", 16'(o.cc), 16'hf);
        check("rst_async_seg", 16'(o.seg), 16'h0);
        check("rst_async_dp", 16'(o.dp), 16'h0);
        we = 1'b1;
        addr = 2'd3;
        din = 16'hffff;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b0;
        e = 0;
        sb.delete();
        for (int k = 0; k < 4; k++) mreg[k] = '0;
        for (int k = 0; k < 4; k++) begin
            addr = 2'(k);
            #1;
            check($sformatf("rst_dout%0d", k), dout, 16'h0);
        end
        o = actual();
        check("rst_idle_cc", 16'(o.cc), 16'hf);
        check("rst_idle_seg", 16'(o.seg), 16'h0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        vec_t tbl [4];
        int guard;
        tbl = '{
            '{2'd2, 16'h0201, 16'h0201},
            '{2'd3, 16'h7c55, 16'h7c55},
            '{2'd0, 16'h8008, 16'h8008},
            '{2'd1, 16'h0100, 16'h0100}
        };
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 40; k++) step(1'b0, 2'd0, 16'h0);
        for (int v = 0; v < 4; v++) begin
            step(1'b1, tbl[v].a, tbl[v].d);
            addr = tbl[v].a;
            #1;
            check($sformatf("dout_vec%0d", v), dout, tbl[v].rd);
            for (int k = 0; k < 9; k++) step(1'b0, 2'd0, 16'h0);
        end
        for (int k = 0; k < 4 * DIV; k++) begin
            step(1'b0, 2'd0, 16'h0);
            if (expect_at(e).cc == 4'b1110)
                check($sformatf("hex8@%0d", e), 16'({G, F, E, D, C, B, A}), 16'(HEX8_EXP));
        end
        guard = 0;
        while (!(((e / DIV) % 4 == 1) && (e % DIV == 4)) && guard < 64) begin
            step(1'b0, 2'd0, 16'h0);
            guard++;
        end
        check("live_guard", 16'(guard < 64), 16'd1);
        step(1'b1, 2'd1, 16'h0002);
        step(1'b0, 2'd0, 16'h0);
        check("live_b", 16'(B), 16'd1);
        check("live_cc2", 16'(CC2), 16'd0);
        guard = 0;
        while (expect_at(e).cc != 4'b0111 && guard < 64) begin
            step(1'b0, 2'd0, 16'h0);
            guard++;
        end
        check("cc4_guard", 16'(guard < 64), 16'd1);
        check("cc4_lit", 16'(CC4), 16'd0);
        do_reset();
        for (int k = 0; k < BLANK + 1; k++) step(1'b0, 2'd0, 16'h0);
        check("first_cc1", 16'({CC4, CC3, CC2, CC1}), 16'he);
        for (int k = 0; k < 2 * DIV; k++) step(1'b0, 2'd0, 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
